// File: rtl/adsr_env_if.sv
// Note/parameter inputs and envelope outputs between the key decoder, the
// ADSR sequencer and the synthesizer voice.
interface adsr_env_if #(
  parameter int PHASE_BITS = 32,
  parameter int VOL_WIDTH  = 9
);
  logic                  sample_tick_in;
  logic                  note_on_in;
  logic                  note_off_in;
  logic [PHASE_BITS-1:0] phase_incr_in;
  logic [7:0]            attack_rate_in;
  logic [7:0]            decay_rate_in;
  logic [VOL_WIDTH-1:0]  sustain_lvl_in;
  logic [7:0]            release_rate_in;
  logic [VOL_WIDTH-1:0]  vol_out;
  logic [PHASE_BITS-1:0] phase_incr_out;
  logic                  active_out;
  logic [2:0]            state_out;

  modport master (
    output sample_tick_in, note_on_in, note_off_in, phase_incr_in,
           attack_rate_in, decay_rate_in, sustain_lvl_in, release_rate_in,
    input  vol_out, phase_incr_out, active_out, state_out
  );

  modport slave (
    input  sample_tick_in, note_on_in, note_off_in, phase_incr_in,
           attack_rate_in, decay_rate_in, sustain_lvl_in, release_rate_in,
    output vol_out, phase_incr_out, active_out, state_out
  );
endinterface

// File: rtl/adsr_envelope_ctrl.sv
// Per-voice ADSR envelope sequencer: note events latch pitch and step the FSM,
// volume moves once per sample tick. ENV_EXP_RELEASE_EN selects exponential release.
module adsr_envelope_ctrl #(
  parameter int PHASE_BITS = 32,
  parameter int VOL_WIDTH  = 9,
  parameter int VOL_MAX    = 256
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  adsr_env_if.slave   env
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int W = VOL_WIDTH + 1;
  typedef logic [W-1:0] wv_t;
  localparam wv_t VMAX_W = wv_t'(VOL_MAX);
  localparam logic [VOL_WIDTH-1:0] VMAX = VOL_WIDTH'(VOL_MAX);

  state_t                state, state_n;
  logic [VOL_WIDTH-1:0]  vol, vol_n;
  logic [PHASE_BITS-1:0] phase, phase_n;
  logic                  active;

  wv_t vol_w, sus_w, s_clamp, att_sum, dec_floor, rel_step;
  logic rel_instant;

  // One extra bit of headroom so sums and differences can be compared without wrapping.
  assign vol_w     = {1'b0, vol};
  assign sus_w     = {1'b0, env.sustain_lvl_in};
  assign s_clamp   = (sus_w > VMAX_W) ? VMAX_W : sus_w;
  assign att_sum   = vol_w + wv_t'(env.attack_rate_in);
  assign dec_floor = s_clamp + wv_t'(env.decay_rate_in);

`ifdef ENV_EXP_RELEASE_EN
  wv_t exp_step;
  assign exp_step    = vol_w >> env.release_rate_in[2:0];
  assign rel_step    = (exp_step == '0) ? wv_t'(1) : exp_step;
  assign rel_instant = (env.release_rate_in[2:0] == 3'd0);
`else
  assign rel_step    = wv_t'(env.release_rate_in);
  assign rel_instant = (env.release_rate_in == 8'd0);
`endif

  always_comb begin
    state_n = state;
    vol_n   = vol;
    phase_n = phase;
    if (env.note_on_in) begin
      // legato retrigger: volume is kept so there is no click
      state_n = ATTACK;
      phase_n = env.phase_incr_in;
    end else if (env.note_off_in) begin
      if (state == ATTACK || state == DECAY || state == SUSTAIN) state_n = RELEASE;
    end else if (env.sample_tick_in) begin
      case (state)
        IDLE: vol_n = '0;
        ATTACK:
          if (env.attack_rate_in == 8'd0 || att_sum >= VMAX_W) begin
            vol_n   = VMAX;
            state_n = DECAY;
          end else begin
            vol_n = VOL_WIDTH'(att_sum);
          end
        DECAY:
          if (env.decay_rate_in == 8'd0 || vol_w <= dec_floor) begin
            vol_n   = VOL_WIDTH'(s_clamp);
            state_n = SUSTAIN;
          end else begin
            vol_n = VOL_WIDTH'(vol_w - wv_t'(env.decay_rate_in));
          end
        SUSTAIN: vol_n = VOL_WIDTH'(s_clamp);
        RELEASE:
          if (rel_instant || rel_step >= vol_w) begin
            vol_n   = '0;
            state_n = IDLE;
          end else begin
            vol_n = VOL_WIDTH'(vol_w - rel_step);
          end
        default: begin
          vol_n   = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state  <= IDLE;
      vol    <= '0;
      phase  <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_n;
      vol    <= vol_n;
      phase  <= phase_n;
      active <= (state_n != IDLE);
    end
  end

  assign env.vol_out        = vol;
  assign env.phase_incr_out = phase;
  assign env.active_out     = active;
  assign env.state_out      = state;
endmodule
